modbus_rtu_rx_framer: RTL

//  Receive-side Modbus RTU framer/checker between the UART byte receiver and the slave request parser.

---
 rtl/modbus_pkg.sv | 29 ++
 rtl/modbus_rtu_rx_framer_gap_timer.sv | 36 +++
 rtl/modbus_rtu_rx_framer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/modbus_pkg.sv
// Shared Modbus RTU definitions: CRC16 constants and byte-step function, broadcast address, framer states.
// Latency: n/a (package only).
// Backpressure: n/a.
package modbus_pkg;

  localparam logic [15:0] CRC_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC_POLY      = 16'hA001;
  localparam logic [7:0]  MB_BCAST_ADDR = 8'h00;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    RECV,
    GAP,
    CHECK,
    HOLD
  } framer_state_t;

  // One byte of the reflected Modbus CRC16, LSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/modbus_rtu_rx_framer_gap_timer.sv
// Saturating inter-character silence counter with t1.5 / t3.5 thresholds; shared with the TX path.
// Latency: hit flags reflect the registered count; count clears the cycle after rx_valid.
// Backpressure: none, free-running.
// Ports: clk, rst (sync, active-high), rx_valid (clears count), t15_hit (count >= T15_CYC),
//        t35_hit (count saturated at T35_CYC).
module rtu_gap_timer #(
  parameter int T15_CYC = 750,
  parameter int T35_CYC = 1750
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_valid,
  output logic t15_hit,
  output logic t35_hit
);

  localparam int CW = $clog2(T35_CYC + 1);
  localparam logic [CW-1:0] T15_W = CW'(T15_CYC);
  localparam logic [CW-1:0] T35_W = CW'(T35_CYC);

  logic [CW-1:0] sil_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sil_cnt <= '0;
    end else if (rx_valid) begin
      sil_cnt <= '0;
    end else if (sil_cnt != T35_W) begin
      sil_cnt <= sil_cnt + 1'b1;
    end
  end

  assign t15_hit = (sil_cnt >= T15_W);
  assign t35_hit = (sil_cnt == T35_W);

endmodule

// File: rtl/modbus_rtu_rx_framer.sv
// Modbus RTU receive framer: silence-delimited framing, CRC16 check, slave address filter, held frame buffer.
// Latency: verdict one cycle after t3.5 silence; rd_data registered, one cycle after rd_addr.
// Backpressure: a held frame blocks reception until frm_release; bytes arriving meanwhile are dropped.
// Ports: clk, rst (sync, active-high); rx_data/rx_valid/rx_err from the UART; my_addr slave address;
//        frm_ready/frm_len/frm_bcast describe the held frame; frm_release frees it; rd_addr/rd_data read
//        the buffer; crc_err and frm_drop are single-cycle verdict pulses.
module modbus_rtu_rx_framer
  import modbus_pkg::*;
#(
  parameter int T15_CYC = 750,
  parameter int T35_CYC = 1750,
  parameter int MAX_LEN = 256,
  parameter int AW      = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          rx_err,
  input  logic [7:0]    my_addr,
  output logic          frm_ready,
  output logic [AW-1:0] frm_len,
  output logic          frm_bcast,
  input  logic          frm_release,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          crc_err,
  output logic          frm_drop
);

  localparam int BW = $clog2(MAX_LEN);
  localparam logic [AW-1:0] MAX_LEN_W = AW'(MAX_LEN);
  localparam logic [AW-1:0] MIN_LEN_W = AW'(4);

  framer_state_t state;
  logic [AW-1:0] cnt;
  logic [15:0]   crc;
  logic          bad;
  logic [7:0]    addr_byte;   // copy of buf[0]; the RAM read port belongs to the consumer
  logic          hold_seen;   // any byte arrived while a frame was held
  logic          t15_hit;
  logic          t35_hit;

  logic [7:0]    mem [0:MAX_LEN-1];
  logic          wr_en;
  logic [BW-1:0] wr_idx;

  rtu_gap_timer #(
    .T15_CYC (T15_CYC),
    .T35_CYC (T35_CYC)
  ) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .t15_hit  (t15_hit),
    .t35_hit  (t35_hit)
  );

  // Buffer writes only happen while a frame is being assembled, so HOLD leaves it frozen.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = cnt[BW-1:0];
    case (state)
      IDLE: begin
        wr_en  = rx_valid;
        wr_idx = '0;
      end
      RECV:    wr_en = rx_valid && !t15_hit && (cnt != MAX_LEN_W);
      default: wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= rx_data;
    end
  end

  // Out-of-range reads keep the previous value rather than indexing past the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_addr < MAX_LEN_W) begin
      rd_data <= mem[rd_addr[BW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_IDLE;
      cnt       <= '0;
      crc       <= CRC_INIT;
      bad       <= 1'b0;
      addr_byte <= '0;
      hold_seen <= 1'b0;
      frm_ready <= 1'b0;
      frm_len   <= '0;
      frm_bcast <= 1'b0;
      crc_err   <= 1'b0;
      frm_drop  <= 1'b0;
    end else begin
      crc_err  <= 1'b0;
      frm_drop <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          // A byte landing on the expiry cycle restarts the wait; it belongs to a frame we never saw begin.
          if (t35_hit && !rx_valid) state <= IDLE;
        end
        IDLE: begin
          if (rx_valid) begin
            state     <= RECV;
            cnt       <= AW'(1);
            crc       <= crc16_step(CRC_INIT, rx_data);
            bad       <= rx_err;
            addr_byte <= rx_data;
          end
        end
        RECV: begin
          if (t15_hit) begin
            if (rx_valid) begin
              frm_drop <= 1'b1;
              state    <= WAIT_IDLE;
            end else begin
              state <= GAP;
            end
          end else begin
            if (rx_err) bad <= 1'b1;
            if (rx_valid) begin
              crc <= crc16_step(crc, rx_data);
              if (cnt == MAX_LEN_W) bad <= 1'b1;
              else                  cnt <= cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (rx_valid) begin
            frm_drop <= 1'b1;
            state    <= WAIT_IDLE;
          end else if (t35_hit) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (bad || (cnt < MIN_LEN_W)) begin
            frm_drop <= 1'b1;
            state    <= IDLE;
          end else if (crc != 16'h0000) begin
            crc_err <= 1'b1;
            state   <= IDLE;
          end else if ((addr_byte != my_addr) && (addr_byte != MB_BCAST_ADDR)) begin
            state <= IDLE;
          end else begin
            state     <= HOLD;
            frm_ready <= 1'b1;
            frm_len   <= cnt - AW'(2);
            frm_bcast <= (addr_byte == MB_BCAST_ADDR);
            hold_seen <= 1'b0;
          end
        end
        HOLD: begin
          if (rx_valid) begin
            hold_seen <= 1'b1;
            // First byte seen in HOLD, or first byte after t3.5 silence, opens a new (dropped) frame.
            if (!hold_seen || t35_hit) frm_drop <= 1'b1;
          end
          if (frm_release) begin
            frm_ready <= 1'b0;
            state     <= (hold_seen || rx_valid) ? WAIT_IDLE : IDLE;
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule
